tron_arena: RTL and testbench
=============================

# tron_arena

Parametrised light-cycle arena for N players on a W×H grid. It tracks permanent trails in an on-chip occupancy bitmap and detects wall, trail, out-of-bounds and head-on crashes. It maintains the alive set, declares the round winner or a draw, and emits one paint event per trail cell for the VGA painter. It sits between the per-player movement controllers and the frame-buffer painter, replacing the fixed two-player 64×64 grid.

## Interface
Parameters:
- NUM_PLAYERS, 4, number of players N (2..8)
- GRID_W, 64, columns (need not be a power of two)
- GRID_H, 64, rows
- derived XW = $clog2(GRID_W), YW = $clog2(GRID_H), PID_BITS = $clog2(NUM_PLAYERS)

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- clear  in  1  start new round: wipe bitmap, revive all players
- move_valid  in  1  new head positions for all players present
- move_ready  out  1  block accepts a move this cycle
- play_x  in  NUM_PLAYERS*XW  player i column at [i*XW +: XW]
- play_y  in  NUM_PLAYERS*YW  player i row at [i*YW +: YW]
- alive  out  NUM_PLAYERS  current alive mask
- crash_valid  out  1  one-cycle pulse: crash_mask valid
- crash_mask  out  NUM_PLAYERS  players eliminated by this move
- round_over  out  1  one-cycle pulse: alive count dropped to ≤1
- winner_valid  out  1  with round_over: exactly one survivor
- winner_id  out  PID_BITS  survivor index
- paint_valid  out  1  paint event present
- paint_pos  out  YW+XW  {row, column}
- paint_val  out  PID_BITS+1  {1'b1 trail, owner id}

## Operation
- Bitmap: GRID_W*GRID_H cells, each {occupied, owner}; address = y*GRID_W + x.
- States: CLEAR, IDLE, CHECK, COMMIT, EVAL, DONE.
- CLEAR: writes one empty cell per cycle from address 0 to the last address, then sets alive to all ones and enters IDLE.
- IDLE: move_ready=1. On move_valid&move_ready, latch play_x/play_y and enter CHECK.
- CHECK: a player dies this move if it is alive and any of the following holds:
  - x ≥ GRID_W or y ≥ GRID_H (out of bounds; no bitmap read)
  - its cell is occupied by any owner, including itself (standing still is fatal)
  - another alive player has an identical new position (head-on; all such players die)
- Dead players are ignored entirely: no check, no write, no paint.
- Crossing through each other kills both, because each head is already trail.
- COMMIT: for each alive, non-dying player in index order, write {1, i} and emit paint_pos={y,x}, paint_val={1,i}.
- EVAL:
  - alive &= ~dying.
  - If dying≠0, pulse crash_valid with crash_mask=dying.
  - If popcount(alive_new) ≤ 1, pulse round_over. winner_valid=1 with winner_id when exactly one player survives; a draw is round_over with winner_valid=0. Then enter DONE; otherwise enter IDLE.
- DONE: move_ready=0, move_valid ignored until clear.
- clear (sampled high in any state) has priority over move_valid and aborts any in-progress move without pulses or alive update; writes already committed are wiped by CLEAR.

## Timing
- Reset values:
  - state=CLEAR, move_ready=0, alive=0
  - all pulses 0, paint_valid=0, paint_pos=0, paint_val=0, winner_id=0, crash_mask=0
- Bitmap read latency is 1 cycle (synchronous).
- CHECK takes N+1 cycles: cycle c issues the read for player c (c<N) and evaluates player c-1 (c≥1).
- COMMIT takes N cycles, one player slot each; paint_valid is high only in surviving slots.
- EVAL takes 1 cycle; its outputs are registered and appear the cycle after EVAL.
- Accept edge to move_ready high again: 2N+2 cycles (10 for N=4).
- CLEAR takes GRID_W*GRID_H cycles (4096 default), plus 1 cycle to IDLE.
- paint_valid is never backpressured; the painter must sink 1 event/cycle.

## Structure
- Package arena_pkg: state enum, cell struct {occupied, owner}, paint_val encoding, and the clog2-derived width helpers.
- Sub-module arena_bitmap: single-port synchronous RAM, depth GRID_W*GRID_H, width PID_BITS+1. Single-port is sufficient because read (CHECK) and write (CLEAR/COMMIT) phases never overlap.
- The head-on comparator is an N×N combinational equality array over the latched positions.

## Test plan
- Reset, then clear: move_ready stays low 4097 cycles, then goes high; alive=4'b1111.
- Four distinct in-bounds moves: 4 paint events with paint_val={1,0}..{1,3}; no crash_valid; move_ready returns 10 cycles after accept.
- Player 2 repeats its previous position: crash_valid with crash_mask=4'b0100; alive=4'b1011; no paint for player 2.
- Players 0 and 1 move to the same cell (5,5) while players 2 and 3 are already dead: crash_mask=4'b0011, round_over=1, winner_valid=0 (draw); state DONE ignores the next move_valid.
- Player 3 x=GRID_W while others are safe, with only 0 and 3 alive: crash_mask=4'b1000, round_over=1, winner_valid=1, winner_id=0.
- clear asserted mid-COMMIT: no pulses, alive unchanged until CLEAR completes, bitmap fully empty (a follow-up move into previously painted cells does not crash).

Source files
------------

// File: rtl/arena_pkg.sv
// Shared types and helpers for the light-cycle arena: FSM states, bitmap cell
// layout and the paint/trail code stored per cell.
package arena_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_CHECK,
    ST_COMMIT,
    ST_EVAL,
    ST_DONE
  } state_t;

  localparam int unsigned MAX_PID_BITS = 3;

  typedef struct packed {
    logic                    occupied;
    logic [MAX_PID_BITS-1:0] owner;
  } cell_t;

  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Trail code {1'b1, owner}; callers truncate to pid_bits+1.
  function automatic logic [MAX_PID_BITS:0] paint_code(input int unsigned id,
                                                       input int unsigned pid_bits);
    return (MAX_PID_BITS+1)'((32'd1 << pid_bits) | id);
  endfunction

endpackage

// File: rtl/arena_bitmap.sv
// Single-port synchronous occupancy RAM; the read port returns only the
// occupied flag, one cycle after the address is presented.
module arena_bitmap #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 3,
  parameter int AW    = 12
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             rd_occupied
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rd_occupied <= mem[addr][WIDTH-1];
  end

endmodule

// File: rtl/tron_arena.sv
// N-player light-cycle arena: trail bitmap, crash detection, alive tracking,
// winner/draw decision and one paint event per new trail cell.
module tron_arena
  import arena_pkg::*;
#(
  parameter  int NUM_PLAYERS = 4,
  parameter  int GRID_W      = 64,
  parameter  int GRID_H      = 64,
  localparam int XW          = width_of(GRID_W),
  localparam int YW          = width_of(GRID_H),
  localparam int PID_BITS    = width_of(NUM_PLAYERS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      move_valid,
  output logic                      move_ready,
  input  logic [NUM_PLAYERS*XW-1:0] play_x,
  input  logic [NUM_PLAYERS*YW-1:0] play_y,
  output logic [NUM_PLAYERS-1:0]    alive,
  output logic                      crash_valid,
  output logic [NUM_PLAYERS-1:0]    crash_mask,
  output logic                      round_over,
  output logic                      winner_valid,
  output logic [PID_BITS-1:0]       winner_id,
  output logic                      paint_valid,
  output logic [YW+XW-1:0]          paint_pos,
  output logic [PID_BITS:0]         paint_val
);

  localparam int DEPTH = GRID_W * GRID_H;
  localparam int AW    = width_of(DEPTH);
  localparam int CW    = width_of(DEPTH + 1);
  localparam int NW    = width_of(NUM_PLAYERS + 1);

  state_t                 state;
  logic [CW-1:0]          clr_addr;
  logic [NW-1:0]          cnt;
  logic [XW-1:0]          pos_x [NUM_PLAYERS];
  logic [YW-1:0]          pos_y [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] dying;

  logic [NUM_PLAYERS-1:0] oob;
  logic [NUM_PLAYERS-1:0] headon;
  logic [AW-1:0]          cell_addr [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] alive_new;
  logic [PID_BITS-1:0]    win_idx;

  logic                   ram_we;
  logic [AW-1:0]          ram_addr;
  logic [PID_BITS:0]      ram_wdata;
  logic                   rd_occupied;

  arena_bitmap #(
    .DEPTH (DEPTH),
    .WIDTH (PID_BITS + 1),
    .AW    (AW)
  ) u_bitmap (
    .clock       (clock),
    .we          (ram_we),
    .addr        (ram_addr),
    .wdata       (ram_wdata),
    .rd_occupied (rd_occupied)
  );

  // Out-of-bounds heads get address 0 so the RAM is never indexed past DEPTH.
  always_comb begin
    oob    = '0;
    headon = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      oob[i]       = (int'(pos_x[i]) >= GRID_W) || (int'(pos_y[i]) >= GRID_H);
      cell_addr[i] = oob[i] ? '0 : AW'(int'(pos_y[i]) * GRID_W + int'(pos_x[i]));
      for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
        if (j != i && alive[j] && pos_x[i] == pos_x[j] && pos_y[i] == pos_y[j])
          headon[i] = 1'b1;
      end
    end
  end

  always_comb begin
    alive_new = alive & ~dying;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++)
      if (alive_new[i]) win_idx = PID_BITS'(i);
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      ST_CLEAR: begin
        if (clr_addr != CW'(DEPTH)) begin
          ram_we   = 1'b1;
          ram_addr = AW'(clr_addr);
        end
      end
      ST_CHECK, ST_COMMIT: begin
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
          if (cnt == NW'(i)) begin
            ram_addr = cell_addr[i];
            if (state == ST_COMMIT && alive[i] && !dying[i]) begin
              ram_we    = 1'b1;
              ram_wdata = (PID_BITS+1)'(paint_code(i, PID_BITS));
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_CLEAR;
      clr_addr     <= '0;
      cnt          <= '0;
      dying        <= '0;
      move_ready   <= 1'b0;
      alive        <= '0;
      crash_valid  <= 1'b0;
      crash_mask   <= '0;
      round_over   <= 1'b0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
      paint_valid  <= 1'b0;
      paint_pos    <= '0;
      paint_val    <= '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else begin
      crash_valid  <= 1'b0;
      round_over   <= 1'b0;
      winner_valid <= 1'b0;
      paint_valid  <= 1'b0;
      if (clear) begin
        state      <= ST_CLEAR;
        clr_addr   <= '0;
        move_ready <= 1'b0;
      end else begin
        case (state)
          ST_CLEAR: begin
            if (clr_addr == CW'(DEPTH)) begin
              alive      <= '1;
              move_ready <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
          ST_IDLE: begin
            if (move_valid && move_ready) begin
              for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                pos_x[i] <= play_x[i*XW +: XW];
                pos_y[i] <= play_y[i*YW +: YW];
              end
              dying      <= '0;
              cnt        <= '0;
              move_ready <= 1'b0;
              state      <= ST_CHECK;
            end
          end
          // Read for player cnt is issued now; player cnt-1's data is back.
          ST_CHECK: begin
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
              if (cnt == NW'(i + 1) && alive[i] && (oob[i] || rd_occupied || headon[i]))
                dying[i] <= 1'b1;
            end
            if (cnt == NW'(NUM_PLAYERS)) begin
              cnt   <= '0;
              state <= ST_COMMIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_COMMIT: begin
            for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
              if (cnt == NW'(i) && alive[i] && !dying[i]) begin
                paint_valid <= 1'b1;
                paint_pos   <= {pos_y[i], pos_x[i]};
                paint_val   <= (PID_BITS+1)'(paint_code(i, PID_BITS));
              end
            end
            if (cnt == NW'(NUM_PLAYERS - 1)) begin
              cnt   <= '0;
              state <= ST_EVAL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_EVAL: begin
            alive       <= alive_new;
            crash_valid <= |dying;
            crash_mask  <= dying;
            if ($countones(alive_new) <= 1) begin
              round_over   <= 1'b1;
              winner_valid <= ($countones(alive_new) == 1);
              winner_id    <= win_idx;
              state        <= ST_DONE;
            end else begin
              move_ready <= 1'b1;
              state      <= ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tron_arena.sv
// Randomised and directed bench for tron_arena, checked against a cell-map
// model of the arena rules.
module tb_tron_arena;

  localparam int NP = 4;
  localparam int GW = 40;
  localparam int GH = 24;
  localparam int XW = $clog2(GW);
  localparam int YW = $clog2(GH);
  localparam int PB = $clog2(NP);
  localparam int DEPTH = GW * GH;
  localparam int MOVE_LAT = 2 * NP + 2;

  logic               clock;
  logic               reset;
  logic               clear;
  logic               move_valid;
  logic               move_ready;
  logic [NP*XW-1:0]   play_x;
  logic [NP*YW-1:0]   play_y;
  logic [NP-1:0]      alive;
  logic               crash_valid;
  logic [NP-1:0]      crash_mask;
  logic               round_over;
  logic               winner_valid;
  logic [PB-1:0]      winner_id;
  logic               paint_valid;
  logic [YW+XW-1:0]   paint_pos;
  logic [PB:0]        paint_val;

  tron_arena #(
    .NUM_PLAYERS (NP),
    .GRID_W      (GW),
    .GRID_H      (GH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .move_valid   (move_valid),
    .move_ready   (move_ready),
    .play_x       (play_x),
    .play_y       (play_y),
    .alive        (alive),
    .crash_valid  (crash_valid),
    .crash_mask   (crash_mask),
    .round_over   (round_over),
    .winner_valid (winner_valid),
    .winner_id    (winner_id),
    .paint_valid  (paint_valid),
    .paint_pos    (paint_pos),
    .paint_val    (paint_val)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  int            mx [NP];
  int            my [NP];
  int            occ [DEPTH];
  logic [NP-1:0] m_alive;
  bit            m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_wipe();
    for (int a = 0; a < DEPTH; a++) occ[a] = 0;
    m_alive = '1;
    m_done  = 1'b0;
  endtask

  task automatic set_pos(input int i, input int x, input int y);
    mx[i] = x;
    my[i] = y;
  endtask

  task automatic wait_ready(inout int n);
    while (!move_ready && n < DEPTH + 50) begin
      @(posedge clock);
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wait_clear();
    int n;
    clear = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clear = 1'b0;
    n = 0;
    wait_ready(n);
    check("clear_latency", n, DEPTH + 1);
    check("clear_alive", alive, (1 << NP) - 1);
    model_wipe();
  endtask

  // abort_edge > 0 raises clear after that many cycles past the accept edge.
  task automatic run_move(input int abort_edge);
    logic [NP-1:0] dy;
    logic [NP-1:0] a_new;
    int exp_pp[$], exp_pv[$], exp_pi[$], got_pp[$], got_pv[$];
    int ncrash, nround, ready_at, gmask, gwv, gwid, nsurv, wid, n, npre;
    dy = '0;
    for (int i = 0; i < NP; i++) begin
      if (m_alive[i]) begin
        if (mx[i] >= GW || my[i] >= GH) dy[i] = 1'b1;
        else if (occ[my[i] * GW + mx[i]] != 0) dy[i] = 1'b1;
        for (int j = 0; j < NP; j++)
          if (j != i && m_alive[j] && mx[j] == mx[i] && my[j] == my[i]) dy[i] = 1'b1;
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (m_alive[i] && !dy[i]) begin
        exp_pp.push_back(my[i] * (1 << XW) + mx[i]);
        exp_pv.push_back((1 << PB) | i);
        exp_pi.push_back(i);
      end
    end
    a_new = m_alive & ~dy;
    nsurv = $countones(a_new);
    wid = 0;
    for (int i = 0; i < NP; i++) if (a_new[i]) wid = i;

    check("ready_before_move", move_ready, 1);
    for (int i = 0; i < NP; i++) begin
      play_x[i*XW +: XW] = XW'(mx[i]);
      play_y[i*YW +: YW] = YW'(my[i]);
    end
    move_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    move_valid = 1'b0;
    check("ready_after_accept", move_ready, 0);

    ncrash = 0; nround = 0; ready_at = -1; gmask = 0; gwv = 0; gwid = 0;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clock);
      @(negedge clock);
      if (paint_valid) begin
        got_pp.push_back(int'(paint_pos));
        got_pv.push_back(int'(paint_val));
      end
      if (crash_valid) begin ncrash++; gmask = int'(crash_mask); end
      if (round_over) begin nround++; gwv = int'(winner_valid); gwid = int'(winner_id); end
      if (move_ready && ready_at < 0) ready_at = e;
      clear = (e == abort_edge);
    end

    if (abort_edge > 0) begin
      npre = 0;
      foreach (exp_pi[k]) if (NP + 2 + exp_pi[k] <= abort_edge) npre++;
      check("abort_paint_count", got_pp.size(), npre);
      for (int k = 0; k < npre && k < got_pp.size(); k++) begin
        check("abort_paint_pos", got_pp[k], exp_pp[k]);
        check("abort_paint_val", got_pv[k], exp_pv[k]);
      end
      check("abort_crash_pulses", ncrash, 0);
      check("abort_round_pulses", nround, 0);
      check("abort_alive_held", alive, m_alive);
      n = 16 - (abort_edge + 1);
      wait_ready(n);
      check("abort_clear_latency", n, DEPTH + 1);
      check("abort_alive_after", alive, (1 << NP) - 1);
      model_wipe();
    end else begin
      check("paint_count", got_pp.size(), exp_pp.size());
      for (int k = 0; k < exp_pp.size() && k < got_pp.size(); k++) begin
        check("paint_pos", got_pp[k], exp_pp[k]);
        check("paint_val", got_pv[k], exp_pv[k]);
      end
      check("crash_pulses", ncrash, (dy != 0) ? 1 : 0);
      if (dy != 0) check("crash_mask", gmask, dy);
      check("round_pulses", nround, (nsurv <= 1) ? 1 : 0);
      if (nsurv <= 1) begin
        check("winner_valid", gwv, (nsurv == 1) ? 1 : 0);
        if (nsurv == 1) check("winner_id", gwid, wid);
      end
      check("ready_latency", ready_at, (nsurv <= 1) ? -1 : MOVE_LAT);
      check("alive", alive, a_new);
      for (int i = 0; i < NP; i++)
        if (m_alive[i] && !dy[i]) occ[my[i] * GW + mx[i]] = i + 1;
      m_alive = a_new;
      m_done  = (nsurv <= 1);
    end
  endtask

  task automatic poke_done();
    int ev;
    ev = 0;
    for (int i = 0; i < NP; i++) set_pos(i, 20 + i, 20);
    for (int i = 0; i < NP; i++) begin
      play_x[i*XW +: XW] = XW'(mx[i]);
      play_y[i*YW +: YW] = YW'(my[i]);
    end
    move_valid = 1'b1;
    for (int c = 0; c < 3 * MOVE_LAT; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (move_ready || paint_valid || crash_valid || round_over) ev++;
    end
    move_valid = 1'b0;
    check("done_ignores_move", ev, 0);
    check("done_alive_held", alive, m_alive);
  endtask

  task automatic random_pos();
    for (int i = 0; i < NP; i++) begin
      mx[i] = ($urandom_range(0, 15) == 0) ? GW + int'($urandom_range(0, 23))
                                           : int'($urandom_range(0, 7));
      my[i] = ($urandom_range(0, 15) == 0) ? GH + int'($urandom_range(0, 7))
                                           : int'($urandom_range(0, 4));
    end
  endtask

  initial begin
    reset      = 1'b1;
    clear      = 1'b0;
    move_valid = 1'b0;
    play_x     = '0;
    play_y     = '0;
    repeat (3) @(negedge clock);
    check("rst_move_ready", move_ready, 0);
    check("rst_alive", alive, 0);
    check("rst_crash_valid", crash_valid, 0);
    check("rst_crash_mask", crash_mask, 0);
    check("rst_round_over", round_over, 0);
    check("rst_winner_valid", winner_valid, 0);
    check("rst_winner_id", winner_id, 0);
    check("rst_paint_valid", paint_valid, 0);
    check("rst_paint_pos", paint_pos, 0);
    check("rst_paint_val", paint_val, 0);
    reset = 1'b0;
    @(negedge clock);
    wait_clear();

    // distinct moves, self-repeat crash, trail crash, head-on draw
    set_pos(0, 1, 1); set_pos(1, 3, 1); set_pos(2, 5, 1); set_pos(3, 7, 1);
    run_move(0);
    set_pos(0, 1, 2); set_pos(1, 3, 2); set_pos(2, 5, 1); set_pos(3, 7, 2);
    run_move(0);
    check("p2_dead_alive", alive, 4'b1011);
    set_pos(0, 1, 3); set_pos(1, 3, 3); set_pos(2, 9, 9); set_pos(3, 1, 1);
    run_move(0);
    set_pos(0, 5, 5); set_pos(1, 5, 5); set_pos(2, 6, 6); set_pos(3, 7, 7);
    run_move(0);
    check("draw_alive", alive, 0);
    poke_done();

    // out-of-bounds kill leaves a single winner
    wait_clear();
    set_pos(0, 0, 0); set_pos(1, 10, 10); set_pos(2, 10, 10); set_pos(3, 2, 0);
    run_move(0);
    set_pos(0, 0, 1); set_pos(1, 11, 11); set_pos(2, 12, 12); set_pos(3, GW, 0);
    run_move(0);
    check("winner_alive", alive, 4'b0001);

    // clear during COMMIT, then reuse the previously painted cells
    wait_clear();
    set_pos(0, 10, 10); set_pos(1, 12, 10); set_pos(2, 14, 10); set_pos(3, 16, 10);
    run_move(0);
    set_pos(0, 10, 11); set_pos(1, 12, 11); set_pos(2, 14, 10); set_pos(3, 16, 11);
    run_move(NP + 2);
    set_pos(0, 10, 11); set_pos(1, 12, 10); set_pos(2, 14, 10); set_pos(3, 16, 10);
    run_move(0);
    check("post_clear_no_crash", alive, 4'b1111);

    for (int r = 0; r < 5; r++) begin
      int mv;
      wait_clear();
      mv = 0;
      while (!m_done && mv < 30) begin
        random_pos();
        run_move(0);
        mv++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
